// File: rtl/pipe_mux_n_if.sv
// Bus bundle for pipe_mux_n: select inputs, pipeline control and registered outputs.
// out_par is present only when PIPE_MUX_PARITY_EN is defined.
interface pipe_mux_n_if #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int CNT_W  = 16
);
    logic [NUM_IN*WIDTH-1:0] in_data;
    logic [SEL_W-1:0]        sel;
    logic                    in_valid;
    logic                    stall;
    logic                    flush;
    logic [WIDTH-1:0]        out_data;
    logic                    out_valid;
    logic                    sel_err;
    logic [CNT_W-1:0]        stall_cnt;
`ifdef PIPE_MUX_PARITY_EN
    logic                    out_par;
`endif

    modport master (
        output in_data, sel, in_valid, stall, flush,
        input  out_data, out_valid, sel_err, stall_cnt
`ifdef PIPE_MUX_PARITY_EN
        , out_par
`endif
    );

    modport slave (
        input  in_data, sel, in_valid, stall, flush,
        output out_data, out_valid, sel_err, stall_cnt
`ifdef PIPE_MUX_PARITY_EN
        , out_par
`endif
    );
endinterface

// File: rtl/pipe_mux_n.sv
// N-way selector feeding a STAGES-deep registered pipeline with stall, flush, select-error flag
// and saturating stall counter. Optional carried parity bit enabled by PIPE_MUX_PARITY_EN.
module pipe_mux_n #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = 2,
    parameter int STAGES = 1,
    parameter int CNT_W  = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    pipe_mux_n_if.slave  bus
);

    function automatic logic even_par(input logic [WIDTH-1:0] d);
        return ^d;
    endfunction

    logic [WIDTH-1:0]  w_sel_data;
    logic              w_sel_ill;
    logic [WIDTH-1:0]  r_data [STAGES];
    logic [STAGES-1:0] r_vld;
    logic              r_sel_err;
    logic [CNT_W-1:0]  r_stall_cnt;
`ifdef PIPE_MUX_PARITY_EN
    logic [STAGES-1:0] r_par;
`endif

    // Codes at or above NUM_IN match no input and leave the selection at zero.
    always_comb begin
        w_sel_data = '0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (bus.sel == SEL_W'(k)) w_sel_data = bus.in_data[k*WIDTH +: WIDTH];
        end
    end

    assign w_sel_ill = (32'(bus.sel) >= 32'(NUM_IN));

    // Stage 0 captures the selection; stages 1..STAGES-1 shift; flush beats stall beats advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
            r_vld       <= '0;
            r_sel_err   <= 1'b0;
            r_stall_cnt <= '0;
`ifdef PIPE_MUX_PARITY_EN
            r_par       <= '0;
`endif
        end else if (bus.flush) begin
            for (int i = 0; i < STAGES; i++) r_data[i] <= '0;
            r_vld     <= '0;
            r_sel_err <= 1'b0;
`ifdef PIPE_MUX_PARITY_EN
            r_par     <= '0;
`endif
        end else if (bus.stall) begin
            r_sel_err <= 1'b0;
            if (r_stall_cnt != {CNT_W{1'b1}}) r_stall_cnt <= r_stall_cnt + CNT_W'(1);
        end else begin
            r_data[0] <= w_sel_data;
            r_vld[0]  <= bus.in_valid;
`ifdef PIPE_MUX_PARITY_EN
            r_par[0]  <= even_par(w_sel_data);
`endif
            for (int i = 1; i < STAGES; i++) begin
                r_data[i] <= r_data[i-1];
                r_vld[i]  <= r_vld[i-1];
`ifdef PIPE_MUX_PARITY_EN
                r_par[i]  <= r_par[i-1];
`endif
            end
            r_sel_err <= bus.in_valid & w_sel_ill;
        end
    end

    // Outputs come straight from the last stage, never from the inputs.
    assign bus.out_data  = r_data[STAGES-1];
    assign bus.out_valid = r_vld[STAGES-1];
    assign bus.sel_err   = r_sel_err;
    assign bus.stall_cnt = r_stall_cnt;
`ifdef PIPE_MUX_PARITY_EN
    assign bus.out_par   = r_par[STAGES-1];
`endif

endmodule

// File: doc/pipe_mux_n.md
Name: pipe_mux_n

Overview:
Parametrised N-way, WIDTH-bit selector followed by a STAGES-deep register pipeline with per-stage valid bits, stall and flush. It replaces plain combinational 2:1 selects on timing-critical datapath paths, such as forwarding and writeback selection, where a registered result is required. It stalls and flushes in lockstep with the surrounding pipeline control. It also flags illegal select codes and counts stall cycles for debug.

Parameters:
WIDTH, 32, data width of each input and of the output
NUM_IN, 4, number of data inputs (2..16)
SEL_W, 2, select width; must satisfy 2^SEL_W >= NUM_IN
STAGES, 1, register stages between select and output (1..4)
CNT_W, 16, width of the saturating stall counter

Ports:
clk  in  1  rising-edge clock
rst_n  in  1  asynchronous active-low reset
in_data  in  NUM_IN*WIDTH  flattened inputs; input k occupies bits [k*WIDTH +: WIDTH]
sel  in  SEL_W  selects input k
in_valid  in  1  qualifies in_data/sel this cycle
stall  in  1  freeze all stages
flush  in  1  invalidate all stages
out_data  out  WIDTH  final-stage data
out_valid  out  1  final-stage valid
sel_err  out  1  registered pulse: an illegal select was captured
stall_cnt  out  CNT_W  saturating count of stalled cycles

Behaviour:
- Reset (async assert, sync release): all stage data = 0, all stage valids = 0, out_data = 0, out_valid = 0, sel_err = 0, stall_cnt = 0.
- Stage 0 input: if sel < NUM_IN, the selected data is in_data slice sel. If sel >= NUM_IN, the selected data is all-zeros.
- Priority each edge is flush > stall > advance.
- flush: every stage valid <= 0 and stage data <= 0. sel_err <= 0. stall_cnt unaffected.
- stall (no flush): all stages hold their data and valid. sel_err <= 0. stall_cnt increments and saturates at 2^CNT_W-1; it never wraps.
- Advance:
  - Stage 0 <= (selected data, in_valid).
  - Stage i <= stage i-1, for i = 1..STAGES-1.
  - sel_err <= in_valid && (sel >= NUM_IN).
- Latency: an input presented at edge t appears on out_data/out_valid after edge t+STAGES-1, i.e. STAGES clock edges in total, with no stalls.
- Each stall cycle adds exactly one cycle of latency. No data is lost or duplicated across a stall.
- When in_valid = 0, data is still captured, but the stage valid is 0. Consumers must ignore out_data when out_valid = 0.
- out_data/out_valid are driven directly from the last stage register, with no combinational path from inputs.
- Reset asserted mid-stream discards all in-flight data immediately.
- Simultaneous stall and flush: flush wins, and stall_cnt does not increment.

Optional Feature:
Macro: PIPE_MUX_PARITY_EN.
- Defined:
  - Adds output port out_par (1 bit).
  - Even parity of the selected data is computed at stage 0 and carried through every stage with its data.
  - out_par follows the same flush, stall and reset rules as the data, with reset/flush value 0.
- Undefined: the port and its logic are absent, and all other behaviour is identical.

Test Plan:
- Reset/select, NUM_IN=4, STAGES=1: reset, then in_data inputs 0..3 = 0x11111111/0x22222222/0x33333333/0x44444444, sel=2, in_valid=1 -> after 1 edge out_data=0x33333333, out_valid=1.
- Latency, STAGES=3: stream sel=0,1,2,3 on consecutive cycles with the same data -> out_data = 0x11111111, 0x22222222, 0x33333333, 0x44444444 on edges 3..6, each with out_valid=1.
- Stall, STAGES=3: assert stall for 2 cycles mid-stream -> outputs frozen for 2 cycles, sequence resumes without loss or duplication, stall_cnt=2.
- Flush beats stall: assert flush and stall together with 3 items in flight -> out_valid=0 next edge, all data regs 0, stall_cnt unchanged.
- Illegal select, NUM_IN=3, SEL_W=2: sel=3, in_valid=1 -> out_data=0, sel_err=1 for one cycle. Same with in_valid=0 -> sel_err stays 0.
- Counter saturation, CNT_W=4: hold stall for 20 cycles -> stall_cnt=15 and holds. With PIPE_MUX_PARITY_EN, data 0x00000007 -> out_par=1, and data 0x00000003 -> out_par=0.
